blink_arbiter: RTL and testbench

//   Shares one indicator light between NREQ requesters. Each requester asks for
//   a blink burst: a half-period and a blink count. The block picks requesters

---
 rtl/blink_arbiter_pkg.sv | 20 ++
 rtl/blink_arbiter_if.sv | 25 ++
 rtl/blink_arbiter_rr_pick.sv | 31 +++
 rtl/blink_arbiter.sv | 127 ++++++++++++
 tb/tb_blink_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/blink_arbiter_pkg.sv
// Shared types and default widths for the blink arbiter.
package blink_pkg;

    // Burst FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int HP_W_DEF  = 8;
    localparam int CNT_W_DEF = 4;

    // Width of an index into NREQ requesters; at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blink_arbiter_if.sv
// Requester-side bundle: level requests, per-requester burst settings,
// and the arbiter's grant/status/light outputs.
interface blink_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int HP_W  = 8,
    parameter int CNT_W = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*HP_W-1:0]  half_per;
    logic [NREQ*CNT_W-1:0] blinks;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic                  light;

    modport master (
        output req, half_per, blinks,
        input  grant, busy, done, light
    );

    modport slave (
        input  req, half_per, blinks,
        output grant, busy, done, light
    );
endinterface

// File: rtl/blink_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from ptr+1 with wrap-around.
module rr_pick
    import blink_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_next,
    output logic [PW-1:0]   gnt_idx
);
    // Scan the NREQ candidates in priority order starting after ptr.
    always_comb begin
        int  j;
        logic found;
        gnt_next = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found       = 1'b1;
                gnt_next[j] = 1'b1;
                gnt_idx     = PW'(j);
            end
        end
    end
endmodule

// File: rtl/blink_arbiter.sv
// Shares one indicator light between NREQ requesters. Grants round-robin,
// latches the winner's half-period and blink count, runs the on/off
// divider and pulses done when a burst completes without abort.
module blink_arbiter
    import blink_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int HP_W  = HP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic          clk,
    input logic          rst_n,
    blink_arbiter_if.slave bus
);
    localparam int PW = idx_w(NREQ);

    state_t            state;
    logic [NREQ-1:0]   grant_q;
    logic              done_q;
    logic              light_q;
    logic [HP_W-1:0]   cnt;
    logic [HP_W-1:0]   hp;
    logic [CNT_W-1:0]  rem;
    logic [PW-1:0]     ptr;

    logic [NREQ-1:0]   gnt_next;
    logic [PW-1:0]     pick_idx;
    logic [HP_W-1:0]   hp_sel;
    logic [CNT_W-1:0]  n_sel;
    logic              owner_req;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .gnt_next (gnt_next),
        .gnt_idx  (pick_idx)
    );

    // Settings of the candidate winner, captured only on the grant edge.
    always_comb begin
        hp_sel = bus.half_per[int'(pick_idx)*HP_W +: HP_W];
        n_sel  = bus.blinks[int'(pick_idx)*CNT_W +: CNT_W];
    end

    // The owner still holding its request; dropping it aborts the burst.
    assign owner_req = |(bus.req & grant_q);

    // Burst FSM with phase counter; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= 1'b0;
            light_q <= 1'b0;
            cnt     <= '0;
            hp      <= '0;
            rem     <= '0;
            ptr     <= PW'(NREQ - 1);
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q <= gnt_next;
                        ptr     <= pick_idx;
                        hp      <= hp_sel;
                        rem     <= n_sel;
                        cnt     <= '0;
                        if (n_sel == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ON;
                            light_q <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (!owner_req) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        light_q <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt == hp) begin
                        state   <= OFF;
                        cnt     <= '0;
                        light_q <= 1'b0;
                    end else begin
                        cnt <= cnt + HP_W'(1);
                    end
                end
                OFF: begin
                    if (!owner_req) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        light_q <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt == hp) begin
                        cnt <= '0;
                        if (rem != '0) rem <= rem - CNT_W'(1);
                        // rem==1 here means this decrement reaches zero.
                        if (rem <= CNT_W'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ON;
                            light_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + HP_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.light = light_q;
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_blink_arbiter.sv
// Directed bench for blink_arbiter: single burst, round-robin, zero count,
// abort, async reset and sample-at-grant scenarios.
module tb_blink_arbiter;
    localparam int NREQ = 4;
    localparam int HP_W = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;

    blink_arbiter_if #(.NREQ(NREQ), .HP_W(HP_W), .CNT_W(CNT_W)) bus ();

    blink_arbiter #(.NREQ(NREQ), .HP_W(HP_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [7:0] hp, input logic [3:0] n);
        bus.half_per[i*HP_W +: HP_W] = hp;
        bus.blinks[i*CNT_W +: CNT_W] = n;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.half_per = '0;
        bus.blinks = '0;
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({bus.grant, bus.busy, bus.done, bus.light} !== 7'b0) begin
            errs++;
            $display("FAIL reset_outputs got g=%b b=%b d=%b l=%b want all 0",
                     bus.grant, bus.busy, bus.done, bus.light);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.grant, bus.busy} !== 5'b0) begin
            errs++;
            $display("FAIL reset_idle got g=%b b=%b want 0", bus.grant, bus.busy);
        end
    endtask

    // Check one full burst: (hp+1) on, (hp+1) off, n times, then done.
    task automatic check_burst(input string nm, input logic [3:0] g, input int hp, input int n);
        int ph;
        ph = hp + 1;
        for (int c = 0; c < 2 * ph * n; c++) begin
            logic exp_l;
            exp_l = ((c / ph) % 2) == 0;
            vectors++;
            if (bus.light !== exp_l || bus.grant !== g || bus.done !== 1'b0) begin
                errs++;
                $display("FAIL %s_cycle%0d got l=%b g=%b d=%b want l=%b g=%b d=0",
                         nm, c, bus.light, bus.grant, bus.done, exp_l, g);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.grant !== g || bus.light !== 1'b0) begin
            errs++;
            $display("FAIL %s_done got d=%b g=%b l=%b want d=1 g=%b l=0",
                     nm, bus.done, bus.grant, bus.light, g);
        end
    endtask

    task automatic test_single();
        set_req(0, 8'd8, 4'd2);
        bus.req = 4'b0001;
        @(negedge clk);
        check_burst("single", 4'b0001, 8, 2);
        bus.req = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL single_release got g=%b d=%b b=%b want 0 0 0",
                     bus.grant, bus.done, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'd0, 4'd1);
        bus.req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (b % 4);
            @(negedge clk);
            vectors++;
            if (bus.grant !== exp_g || bus.light !== 1'b1) begin
                errs++;
                $display("FAIL rr_on%0d got g=%b l=%b want g=%b l=1", b, bus.grant, bus.light, exp_g);
            end
            @(negedge clk);
            vectors++;
            if (bus.grant !== exp_g || bus.light !== 1'b0 || bus.done !== 1'b0) begin
                errs++;
                $display("FAIL rr_off%0d got g=%b l=%b d=%b want g=%b l=0 d=0",
                         b, bus.grant, bus.light, bus.done, exp_g);
            end
            @(negedge clk);
            vectors++;
            if (bus.grant !== exp_g || bus.done !== 1'b1) begin
                errs++;
                $display("FAIL rr_done%0d got g=%b d=%b want g=%b d=1", b, bus.grant, bus.done, exp_g);
            end
            @(negedge clk);
            vectors++;
            if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
                errs++;
                $display("FAIL rr_idle%0d got g=%b b=%b want 0 0", b, bus.grant, bus.busy);
            end
            if (b == 4) bus.req = '0;
        end
    endtask

    task automatic test_zero_count();
        set_req(2, 8'd7, 4'd0);
        bus.req = 4'b0100;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0100 || bus.done !== 1'b1 || bus.light !== 1'b0) begin
            errs++;
            $display("FAIL zero_done got g=%b d=%b l=%b want 0100 1 0", bus.grant, bus.done, bus.light);
        end
        bus.req = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.done !== 1'b0 || bus.light !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL zero_idle got g=%b d=%b l=%b b=%b want 0", bus.grant, bus.done, bus.light, bus.busy);
        end
    endtask

    task automatic test_abort();
        set_req(1, 8'd5, 4'd3);
        set_req(3, 8'd1, 4'd1);
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = 4'b1010;
        // ON 6, OFF 6, then 3 cycles into the second ON phase.
        for (int c = 0; c < 14; c++) @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0010 || bus.light !== 1'b1) begin
            errs++;
            $display("FAIL abort_mid_on got g=%b l=%b want 0010 1", bus.grant, bus.light);
        end
        bus.req = 4'b1000;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.light !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_idle got g=%b l=%b d=%b b=%b want 0", bus.grant, bus.light, bus.done, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b1000 || bus.light !== 1'b1) begin
            errs++;
            $display("FAIL abort_next_grant got g=%b l=%b want 1000 1", bus.grant, bus.light);
        end
        bus.req = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL abort2_idle got g=%b d=%b want 0 0", bus.grant, bus.done);
        end
    endtask

    task automatic test_async_reset();
        set_req(0, 8'd4, 4'd2);
        bus.req = 4'b0001;
        @(negedge clk);
        for (int c = 0; c < 6; c++) @(negedge clk);
        vectors++;
        if (bus.light !== 1'b0 || bus.busy !== 1'b1 || bus.grant !== 4'b0001) begin
            errs++;
            $display("FAIL ares_mid_off got l=%b b=%b g=%b want 0 1 0001", bus.light, bus.busy, bus.grant);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.grant, bus.busy, bus.done, bus.light} !== 7'b0) begin
            errs++;
            $display("FAIL ares_immediate got g=%b b=%b d=%b l=%b want 0",
                     bus.grant, bus.busy, bus.done, bus.light);
        end
        bus.req = 4'b1001;
        set_req(3, 8'd2, 4'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0001 || bus.light !== 1'b1) begin
            errs++;
            $display("FAIL ares_ptr got g=%b l=%b want 0001 1", bus.grant, bus.light);
        end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_sample_at_grant();
        set_req(0, 8'd3, 4'd2);
        bus.req = 4'b0001;
        @(negedge clk);
        set_req(0, 8'd10, 4'd2);
        check_burst("sample", 4'b0001, 3, 2);
        bus.req = '0;
        @(negedge clk);
        vectors++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL sample_idle got g=%b b=%b want 0 0", bus.grant, bus.busy);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst_n   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_abort();
        test_async_reset();
        test_sample_at_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
